seq_slice_adder: RTL and testbench

//  Multi-cycle WIDTH-bit add/subtract unit for the RISC ALU datapath.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/add_slice.sv | 36 +++
 rtl/seq_slice_adder.sv | 159 +++++++++++++++
 tb/tb_seq_slice_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RISC ALU datapath blocks.
//   - DEFAULT_WIDTH / DEFAULT_SLICE : default operand width and bits per slice
//   - state_t                       : sequential adder FSM encoding
//   - ovf_flag()                    : signed overflow from operand/result MSBs
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: both addends share a sign and the result
  // sign differs from it. b_msb is the MSB of the operand actually added
  // (already inverted for subtraction).
  function automatic logic ovf_flag(input logic a_msb,
                                    input logic b_msb,
                                    input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_slice.sv
// ---------------------------------------------------------------------------
// add_slice
// Combinational SLICE-bit ripple-carry adder, reused once per cycle by the
// sequential adder.
// Ports:
//   a, b  in  SLICE  addend slices
//   cin   in  1      carry in
//   s     out SLICE  sum slice
//   cout  out 1      carry out of the slice MSB
// ---------------------------------------------------------------------------
module add_slice
  import alu_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  // Ripple the carry bit by bit; the local variable keeps the chain inside
  // one process so no combinational loop through a vector is created.
  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < SLICE; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_slice_adder.sv
// ---------------------------------------------------------------------------
// seq_slice_adder
// Multi-cycle WIDTH-bit add/subtract unit. One SLICE-bit slice is added per
// cycle (LSB slice first) with the carry kept in a register, so a WIDTH-bit
// operation takes WIDTH/SLICE RUN cycles through a single small adder.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      a/b/sub valid
//   in_ready   out  1      operands accepted (IDLE only, low during reset)
//   a, b       in   WIDTH  operands
//   sub        in   1      1: a-b, 0: a+b
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      downstream accepts the result
//   result     out  WIDTH  sum / difference (modulo 2^WIDTH)
//   c_out      out  1      carry out of MSB (sub: 1 = no borrow)
//   zero, neg, ovf out 1   status flags, only when SEQ_ADD_FLAGS_EN is defined
//
// Build option: define SEQ_ADD_FLAGS_EN to add the zero/neg/ovf flag ports.
// ---------------------------------------------------------------------------
module seq_slice_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef SEQ_ADD_FLAGS_EN
  output logic             c_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] next_acc;

`ifdef SEQ_ADD_FLAGS_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // The single slice adder always works on the bottom slice of the operand
  // shift registers; the registers shift down after every RUN cycle.
  add_slice #(
    .SLICE (SLICE)
  ) u_add_slice (
    .a    (op_a[SLICE-1:0]),
    .b    (op_b[SLICE-1:0]),
    .cin  (carry),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  // The new slice enters at the top of the accumulator, so after NSLICE
  // shifts the first (least significant) slice has reached bit 0.
  assign next_acc = {slice_sum, acc[WIDTH-1:SLICE]};

  // in_ready is qualified with rst_n so nothing is accepted while reset is
  // being applied, even though the state register only clears on the edge.
  assign in_ready = rst_n && (state == ST_IDLE);

  // The accumulator and carry register double as the output registers: they
  // stop changing once DONE is reached, which gives stable outputs under
  // backpressure without an extra copy.
  assign result = acc;
  assign c_out  = carry;

  // Main FSM plus datapath registers. Subtraction is done as a + ~b + 1 by
  // inverting b at accept time and seeding the carry with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      counter   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
`ifdef SEQ_ADD_FLAGS_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a    <= a;
            op_b    <= sub ? ~b : b;
            carry   <= sub;
            counter <= '0;
            state   <= ST_RUN;
`ifdef SEQ_ADD_FLAGS_EN
            a_msb   <= a[WIDTH-1];
            b_msb   <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
`endif
          end
        end

        ST_RUN: begin
          acc     <= next_acc;
          op_a    <= op_a >> SLICE;
          op_b    <= op_b >> SLICE;
          carry   <= slice_cout;
          counter <= counter + 1'b1;
          if (counter == LAST_SLICE) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
`ifdef SEQ_ADD_FLAGS_EN
            zero      <= (next_acc == '0);
            neg       <= next_acc[WIDTH-1];
            ovf       <= ovf_flag(a_msb, b_msb, next_acc[WIDTH-1]);
`endif
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_slice_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_slice_adder
// Self-checking bench for seq_slice_adder (default 32-bit / 4-bit slices).
// Expected results are computed from a behavioural model when an operation
// is accepted, pushed to a queue, and popped when the DUT presents a result.
// Flag checks are compiled in when SEQ_ADD_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_slice_adder;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 8;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             z;
    logic             n;
    logic             o;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
`ifdef SEQ_ADD_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   cycle;
  int   accept_cycle;

  seq_slice_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef SEQ_ADD_FLAGS_EN
    .c_out     (c_out),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
`else
    .c_out     (c_out)
`endif
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma,
                                 input logic [WIDTH-1:0] mb,
                                 input logic msub);
    exp_t             e;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, msub};
    e.r  = full[WIDTH-1:0];
    e.c  = full[WIDTH];
    e.z  = (e.r == '0);
    e.n  = e.r[WIDTH-1];
    e.o  = (ma[WIDTH-1] == bb[WIDTH-1]) && (e.r[WIDTH-1] != ma[WIDTH-1]);
    return e;
  endfunction

  // Presents an operation, waits (bounded) for acceptance, records the
  // expected result. Returns on the falling edge after the accept edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] sa,
                               input logic [WIDTH-1:0] sb,
                               input logic ssub);
    int n;
    @(negedge clk);
    a        = sa;
    b        = sb;
    sub      = ssub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    accept_cycle = cycle;
    in_valid     = 1'b0;
    exp_q.push_back(model(sa, sb, ssub));
  endtask

  // Waits for out_valid, checks latency/result/flags, optionally holds
  // backpressure for 'hold' cycles, then accepts the result.
  task automatic collectResult(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, "_latency"}, 64'(cycle - accept_cycle), 64'(LATENCY));
    checkOutput({tag, "_result"}, 64'(result), 64'(e.r));
    checkOutput({tag, "_c_out"}, 64'(c_out), 64'(e.c));
`ifdef SEQ_ADD_FLAGS_EN
    checkOutput({tag, "_zero"}, 64'(zero), 64'(e.z));
    checkOutput({tag, "_neg"}, 64'(neg), 64'(e.n));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(e.o));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_hold_result"}, 64'(result), 64'(e.r));
      checkOutput({tag, "_hold_c_out"}, 64'(c_out), 64'(e.c));
      checkOutput({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
`ifdef SEQ_ADD_FLAGS_EN
      checkOutput({tag, "_hold_flags"}, 64'({zero, neg, ovf}),
                  64'({e.z, e.n, e.o}));
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_checks  = 0;
    n_pass    = 0;
    cycle     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_c_out", 64'(c_out), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef SEQ_ADD_FLAGS_EN
    checkOutput("rst_flags", 64'({zero, neg, ovf}), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", 64'(in_ready), 64'd1);

    // Carry out of the MSB, zero result
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    collectResult("add_wrap", 0);

    // Signed overflow into the sign bit
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    collectResult("add_ovf", 0);

    // Subtraction with and without borrow
    applyStimulus(32'd5, 32'd7, 1'b1);
    collectResult("sub_borrow", 0);
    applyStimulus(32'd7, 32'd5, 1'b1);
    collectResult("sub_noborrow", 0);

    // Backpressure in DONE
    applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    collectResult("backpressure", 3);

    // Reset on the 4th RUN cycle aborts the operation
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready_low", 64'(in_ready), 64'd0);
    checkOutput("abort_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    #1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < LATENCY + 2; i++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 64'(out_valid), 64'd0);
    end
    applyStimulus(32'd3, 32'd4, 1'b0);
    collectResult("after_abort", 0);

    // Inputs changing during RUN are ignored
    applyStimulus(32'h0000_1000, 32'h0000_0234, 1'b1);
    in_valid = 1'b1;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0BAD_F00D;
    sub      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    collectResult("busy_ignore", 0);

    // A few pseudo-random operations
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
      collectResult("random", i % 2);
    end

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
